// File: rtl/vending_pkg.sv
// Shared definitions for the vending front end: coin indices, arbiter state encoding
// and the grant-selection helpers used by coin_arbiter.
package vending_pkg;

    localparam int COIN_W = 3;
    localparam int COIN_N = 0;
    localparam int COIN_D = 1;
    localparam int COIN_Q = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // First requesting channel at or after ptr, wrapping nickel -> dime -> quarter.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        case (ptr)
            2'd0:    pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
            2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = 2'd0;
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] fixed_pick(input logic [2:0] req);
        logic [1:0] pick;
        if (req[2]) begin
            pick = 2'd2;
        end else if (req[1]) begin
            pick = 2'd1;
        end else begin
            pick = 2'd0;
        end
        return pick;
    endfunction

    function automatic logic [1:0] ptr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: two-flop synchroniser, stability counter and debounced level.
// rise is combinational and marks the edge on which the level goes 0->1.
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic       s1_r;
    logic       s2_r;
    logic       deb_r;
    logic [7:0] cnt_r;
    logic       hit_s;

    assign hit_s = (s2_r != deb_r) && ((cnt_r + 8'd1) == 8'(DEB_CYCLES));
    assign rise  = hit_s & ~deb_r;

    // Synchronise the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r <= 1'b0;
            cnt_r <= 8'd0;
        end else if (s2_r == deb_r) begin
            cnt_r <= 8'd0;
        end else if (hit_s) begin
            deb_r <= ~deb_r;
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/coin_arbiter.sv
// Debounces the three coin buttons, latches presses as pending requests and
// hands them to the vending FSM one at a time with a lockout gap between grants.
module coin_arbiter
    import vending_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PRIO_RR    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COIN_W-1:0] coin_raw,
    input  logic              stall,
    output logic              nickel,
    output logic              dime,
    output logic              quarter,
    output logic [COIN_W-1:0] pending,
    output logic              overflow
);

    logic [COIN_W-1:0] rise_s;
    logic [COIN_W-1:0] pending_r;
    logic [COIN_W-1:0] grant_r;
    logic [COIN_W-1:0] clr_s;
    logic [1:0]        state_r;
    logic [1:0]        ptr_r;
    logic [1:0]        pick_s;
    logic [7:0]        gap_cnt_r;
    logic              overflow_r;
    logic              go_s;

    for (genvar i = 0; i < COIN_W; i++) begin : g_deb
        coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (reset),
            .raw   (coin_raw[i]),
            .rise  (rise_s[i])
        );
    end

    // Grant decision: only from IDLE, only while the FSM is not busy.
    always_comb begin
        go_s   = 1'b0;
        pick_s = 2'd0;
        clr_s  = 3'b000;
        if ((state_r == ST_IDLE) && !stall && (pending_r != 3'b000)) begin
            go_s   = 1'b1;
            pick_s = (PRIO_RR != 0) ? rr_pick(pending_r, ptr_r) : fixed_pick(pending_r);
            clr_s  = 3'b001 << pick_s;
        end else begin
            go_s   = 1'b0;
            pick_s = 2'd0;
            clr_s  = 3'b000;
        end
    end

    // A fresh press beats a same-edge grant clear; a press on a still-pending channel is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r  <= 3'b000;
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= (pending_r & ~clr_s) | rise_s;
            overflow_r <= |(rise_s & pending_r & ~clr_s);
        end
    end

    // Arbiter state, lockout counter, RR pointer and registered grant pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'd0;
            ptr_r     <= 2'd0;
            grant_r   <= 3'b000;
        end else begin
            grant_r <= clr_s;
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_r <= ST_GRANT;
                        ptr_r   <= ptr_next(pick_s);
                    end
                end
                ST_GRANT: begin
                    gap_cnt_r <= 8'd0;
                    state_r   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'(GAP_CYCLES - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign nickel   = grant_r[COIN_N];
    assign dime     = grant_r[COIN_D];
    assign quarter  = grant_r[COIN_Q];
    assign pending  = pending_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_coin_arbiter.sv
// Directed bench for coin_arbiter (DEB=4, GAP=2) with a round-robin and a fixed-priority instance.
module tb_coin_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] coin_raw;
    logic       stall;
    logic       nickel, dime, quarter, overflow;
    logic [2:0] pending;
    logic       nickel_f, dime_f, quarter_f, overflow_f;
    logic [2:0] pending_f;
    logic [2:0] g, g_f;

    int checks = 0;
    int errors = 0;

    assign g   = {quarter, dime, nickel};
    assign g_f = {quarter_f, dime_f, nickel_f};

    coin_arbiter #(.DEB_CYCLES(4), .GAP_CYCLES(2), .PRIO_RR(1)) u_dut (
        .clk(clk), .reset(reset), .coin_raw(coin_raw), .stall(stall),
        .nickel(nickel), .dime(dime), .quarter(quarter),
        .pending(pending), .overflow(overflow)
    );

    coin_arbiter #(.DEB_CYCLES(4), .GAP_CYCLES(2), .PRIO_RR(0)) u_fix (
        .clk(clk), .reset(reset), .coin_raw(coin_raw), .stall(stall),
        .nickel(nickel_f), .dime(dime_f), .quarter(quarter_f),
        .pending(pending_f), .overflow(overflow_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        coin_raw = 3'b000;
        stall    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        coin_raw = 3'b000;
        stall    = 1'b0;
        #3;
        check("rst_grant", {5'd0, g}, 8'h00);
        check("rst_pending", {5'd0, pending}, 8'h00);
        check("rst_overflow", {7'd0, overflow}, 8'h00);
        do_reset();

        // 1: clean nickel press
        coin_raw = 3'b001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t1_grant", {5'd0, g}, (k == 7) ? 8'h01 : 8'h00);
            check("t1_pending", {5'd0, pending}, (k == 6) ? 8'h01 : 8'h00);
            check("t1_overflow", {7'd0, overflow}, 8'h00);
        end

        // 2: all three on the same edge, RR and fixed order
        do_reset();
        coin_raw = 3'b111;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t2_rr_grant", {5'd0, g},
                  (k == 7) ? 8'h01 : (k == 11) ? 8'h02 : (k == 15) ? 8'h04 : 8'h00);
            check("t2_rr_pending", {5'd0, pending},
                  (k < 6) ? 8'h00 : (k == 6) ? 8'h07 : (k < 11) ? 8'h06 : (k < 15) ? 8'h04 : 8'h00);
            check("t2_fix_grant", {5'd0, g_f},
                  (k == 7) ? 8'h04 : (k == 11) ? 8'h02 : (k == 15) ? 8'h01 : 8'h00);
            check("t2_fix_pending", {5'd0, pending_f},
                  (k < 6) ? 8'h00 : (k == 6) ? 8'h07 : (k < 11) ? 8'h03 : (k < 15) ? 8'h01 : 8'h00);
        end

        // 3: short glitch, then a bouncing press
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            coin_raw = (k <= 2) ? 3'b010 : 3'b000;
            tick();
            check("t3_glitch_grant", {5'd0, g}, 8'h00);
            check("t3_glitch_pending", {5'd0, pending}, 8'h00);
        end
        for (int k = 1; k <= 16; k++) begin
            coin_raw = (k <= 3 || (k >= 5 && k <= 10)) ? 3'b010 : 3'b000;
            tick();
            check("t3_bounce_grant", {5'd0, g}, (k == 11) ? 8'h02 : 8'h00);
            check("t3_bounce_pending", {5'd0, pending}, (k == 10) ? 8'h02 : 8'h00);
        end

        // 4: quarter held off by stall
        do_reset();
        stall = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            coin_raw = (k <= 8) ? 3'b100 : 3'b000;
            tick();
            check("t4_stall_grant", {5'd0, g}, 8'h00);
            check("t4_stall_pending", {5'd0, pending}, (k >= 6) ? 8'h04 : 8'h00);
        end
        stall = 1'b0;
        tick();
        check("t4_release_grant", {5'd0, g}, 8'h04);
        check("t4_release_pending", {5'd0, pending}, 8'h00);
        tick();
        check("t4_after_grant", {5'd0, g}, 8'h00);

        // 5: second nickel press while the first is still pending
        do_reset();
        stall = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            coin_raw = (k <= 8 || k >= 17) ? 3'b001 : 3'b000;
            tick();
            check("t5_overflow", {7'd0, overflow}, (k == 22) ? 8'h01 : 8'h00);
            check("t5_pending", {5'd0, pending}, (k >= 6) ? 8'h01 : 8'h00);
            check("t5_grant", {5'd0, g}, 8'h00);
        end
        stall = 1'b0;
        tick();
        check("t5_release_grant", {5'd0, g}, 8'h01);
        check("t5_release_pending", {5'd0, pending}, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t5_single_grant", {5'd0, g}, 8'h00);
        end

        // 6: asynchronous reset while dime is being granted
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            coin_raw = (k >= 2) ? 3'b111 : 3'b010;
            tick();
        end
        check("t6_pre_grant", {5'd0, g}, 8'h02);
        check("t6_pre_pending", {5'd0, pending}, 8'h05);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_grant", {5'd0, g}, 8'h00);
        check("t6_async_pending", {5'd0, pending}, 8'h00);
        coin_raw = 3'b000;
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t6_post_grant", {5'd0, g}, 8'h00);
            check("t6_post_pending", {5'd0, pending}, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
